fifo_word_packer: RTL
=====================

Name: fifo_word_packer

Overview:
Downstream consumer of the 8-bit byte FIFO. Pops bytes through the FIFO read port (rd_en/rdata/empty) and packs LANES consecutive bytes into one wide word, little-endian by arrival. Presents each word on a valid/ready output interface to the next pipeline stage. A flush request emits a partially filled word with a lane-keep mask.

Parameters:
WIDTH, 8, byte width; must equal the FIFO data width
LANES, 4, bytes per output word (2..8)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO pop request; one byte per cycle high
fifo_rdata  in  WIDTH  FIFO read data, valid the cycle after fifo_rd_en
flush  in  1  single-cycle pulse: emit the partial word
out_valid  out  1  out_data/out_keep hold a word
out_ready  in  1  downstream accepts the word when high with out_valid
out_data  out  WIDTH*LANES  packed word; lane k = bits [k*WIDTH +: WIDTH]
out_keep  out  LANES  lane k holds a real byte when bit k is 1
busy  out  1  any byte in flight, assembled, pending or presented

Behaviour:
- Reset (async, immediate): cnt=0, inflight=0, flush_pend=0, asm register=0, out_valid=0, out_data=0, out_keep=0. fifo_rd_en is forced 0 while rst=1, and busy=0.
- Registers: cnt (0..LANES bytes assembled), inflight (registered copy of fifo_rd_en), flush_pend, asm (LANES lanes), output register.
- fifo_rd_en = !rst && !fifo_empty && !flush_pend && (cnt + inflight < LANES). This is combinational from registers and fifo_empty.
- Capture: on an edge with inflight=1, fifo_rdata is written to lane cnt of asm and cnt increments. The first byte popped goes to lane 0.
- Transfer: on an edge with inflight=0 and (!out_valid || out_ready), a transfer is triggered by either condition:
  - cnt==LANES. asm moves to out_data, out_keep becomes all ones, cnt=0, asm is cleared.
  - flush_pend=1 and 0<cnt<LANES. asm moves to out_data with unused lanes 0, out_keep gets its low cnt bits set, cnt=0, flush_pend=0.
  In both cases out_valid=1. Capture and transfer are mutually exclusive by construction.
- flush_pend is set by a flush pulse. While it is set, no new pops are issued; in-flight bytes still land. It clears in either of these cases:
  - on its transfer edge;
  - when inflight=0 and cnt==0, in which case nothing is emitted.
  A flush with cnt==LANES gets a normal full transfer and then clears. A flush while flush_pend=1 is ignored.
- Output: out_valid drops on an out_ready edge unless a new transfer occurs on that same edge. out_data and out_keep stay stable while out_valid && !out_ready.
- Backpressure: with out_valid held and cnt==LANES, pops stop. No byte is ever dropped or duplicated.
- Throughput: sustained one word per LANES+2 cycles when the FIFO stays non-empty and out_ready=1. The first out_valid comes LANES+2 cycles after the first fifo_rd_en.
- FIFO empty mid-word: pops pause and the partial asm is held indefinitely until more bytes arrive or flush.
- busy = inflight || cnt!=0 || flush_pend || out_valid.
- Reset mid-word: the partial word is discarded. After release, the next byte lands in lane 0.

Test Plan:
- Reset: rst=1 for 15 ns with fifo_empty=0 -> fifo_rd_en=0, out_valid=0, out_data=0, busy=0 throughout.
- Basic pack: write 0x11,0x22,0x33,0x44, out_ready=1 -> exactly 4 rd_en pulses and one out_valid cycle with out_data=0x44332211, out_keep=4'b1111. Then busy=0.
- Backpressure: write 0x01..0x08, out_ready=0 -> word 0x04030201 held stable and 8 pops total. Raise out_ready -> 0x04030201, then 0x08070605 on the next valid.
- Flush: write 0xAA,0xBB,0xCC then pulse flush -> out_data=0x00CCBBAA, out_keep=4'b0111. A second flush with nothing assembled -> no out_valid, and busy=0 within 2 cycles.
- Fill/drain: write 64 bytes 0..63 (FIFO full), out_ready=1 -> 16 words 0x03020100 .. 0x3F3E3D3C in order. FIFO ends empty and rd_en is never high while fifo_empty=1.
- Reset mid-word: after 2 bytes captured, pulse rst -> out_valid=0, cnt=0. Then write 0x55,0x66,0x77,0x88 -> out_data=0x88776655.

Source files
------------

// File: rtl/fifo_word_packer.sv
// Pops bytes from a byte FIFO and packs LANES of them (little-endian by arrival)
// into one word on a valid/ready output; flush emits a partial word with a keep mask.

module fifo_word_packer_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (we)  q <= d;
    else if (clr) q <= '0;
  end
endmodule

module fifo_word_packer #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [WIDTH-1:0]       fifo_rdata,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*LANES-1:0] out_data,
  output logic [LANES-1:0]       out_keep,
  output logic                   busy
);
  localparam int CW = $clog2(LANES + 1);

  logic [CW-1:0]                cnt;
  logic                         inflight;
  logic                         flush_pend;
  logic [LANES-1:0][WIDTH-1:0]  asm_q;
  logic [LANES-1:0][WIDTH-1:0]  out_word;
  logic [LANES-1:0]             keep_next;
  logic [LANES-1:0]             lane_we;
  logic [CW:0]                  occ;
  logic                         capture;
  logic                         slot_free;
  logic                         do_full;
  logic                         do_part;
  logic                         xfer;
  logic                         pend_clr;

  // Bytes already assembled plus the one still crossing the FIFO read latency.
  assign occ        = {1'b0, cnt} + {{CW{1'b0}}, inflight};
  assign fifo_rd_en = !rst && !fifo_empty && !flush_pend && (occ < (CW+1)'(LANES));

  assign capture   = inflight;
  assign slot_free = !out_valid || out_ready;
  assign do_full   = !inflight && slot_free && (cnt == CW'(LANES));
  assign do_part   = !inflight && slot_free && flush_pend &&
                     (cnt != '0) && (cnt != CW'(LANES));
  assign xfer      = do_full || do_part;
  // A flush with nothing assembled and nothing landing simply retires.
  assign pend_clr  = xfer || (!inflight && (cnt == '0));

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_we[k]   = capture && (cnt == CW'(k));
    assign keep_next[k] = (CW'(k) < cnt);
    assign out_word[k]  = keep_next[k] ? asm_q[k] : '0;

    fifo_word_packer_lane #(.WIDTH(WIDTH)) u_lane (
      .clk (clk),
      .rst (rst),
      .we  (lane_we[k]),
      .clr (xfer),
      .d   (fifo_rdata),
      .q   (asm_q[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      inflight   <= 1'b0;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
    end else begin
      inflight <= fifo_rd_en;

      if (capture)   cnt <= cnt + CW'(1);
      else if (xfer) cnt <= '0;

      if (flush_pend) begin
        if (pend_clr) flush_pend <= 1'b0;
      end else if (flush) begin
        flush_pend <= 1'b1;
      end

      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= out_word;
        out_keep  <= keep_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = inflight || (cnt != '0) || flush_pend || out_valid;

endmodule
